adc_pack_stream: RTL

Parametrised successor to the fixed 8-channel ADC RAM bank. It accepts per-channel 256-bit ADC write words and packs the low SAMPLE_W bits of the first PACK_N 16-bit lanes into per-channel RAM. On trigger it reads a programmed address window from all channels in lockstep and streams samples out one per cycle with per-channel enables. It sits between the ADC capture write side and the matrix output stage.

---
 rtl/adc_pack_stream.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/adc_pack_stream.sv
// Per-channel packing RAM bank: keeps the low SAMPLE_W bits of the first PACK_N lanes of each
// write word, then streams a programmed address window from all channels in lockstep, one sample per cycle.
module adc_pack_stream #(
  parameter int NCH      = 8,
  parameter int BUS_W    = 256,
  parameter int LANE_W   = 16,
  parameter int SAMPLE_W = 10,
  parameter int PACK_N   = 10,
  parameter int AW       = 13
) (
  input  logic                    clk_250MHz,
  input  logic                    rst,
  input  logic [NCH-1:0]          wen,
  input  logic [NCH*AW-1:0]       wadrs,
  input  logic [NCH*BUS_W-1:0]    wdat,
  input  logic                    trg,
  input  logic [AW-1:0]           start_adr,
  input  logic [AW:0]             num_words,
  input  logic                    rev_order,
  output logic [NCH-1:0]          out_en,
  output logic [NCH*SAMPLE_W-1:0] out_dat,
  output logic [AW-1:0]           rd_adr,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              STATE
);

  localparam int PW = PACK_N * SAMPLE_W;
  localparam int SW = (PACK_N > 1) ? $clog2(PACK_N) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(PACK_N - 1);
  localparam logic [SW-1:0] S_PREF = SW'(PACK_N - 2);
  localparam logic [AW:0]   K_ONE  = (AW+1)'(1);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    PREF = 4'd1,
    STRM = 4'd2,
    DONE = 4'd3
  } state_t;

  state_t state, state_nxt;

  logic [SW-1:0]         s_cnt;
  logic [SW-1:0]         lane_sel;
  logic [AW:0]           k_cnt;
  logic [AW:0]           num_q;
  logic                  rev_q;
  logic                  rd_issue;
  logic                  last_q;
  logic                  emit;
  logic                  last_word;
  logic                  last_sample;
  logic [NCH*SAMPLE_W-1:0] sel_dat;

  assign last_word   = (k_cnt == num_q - K_ONE);
  assign last_sample = (s_cnt == S_LAST);
  // last_q holds STRM one extra cycle so the final sample is on out_en before DONE.
  assign emit        = (state == STRM) && !last_q;
  assign lane_sel    = rev_q ? (S_LAST - s_cnt) : s_cnt;

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign STATE = state;

  always_ff @(posedge clk_250MHz) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trg) state_nxt = (num_words == '0) ? DONE : PREF;
      PREF:    state_nxt = STRM;
      STRM:    if (last_q) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_250MHz) begin
    if (!rst) begin
      s_cnt    <= '0;
      k_cnt    <= '0;
      num_q    <= '0;
      rev_q    <= 1'b0;
      rd_adr   <= '0;
      rd_issue <= 1'b0;
      last_q   <= 1'b0;
      out_en   <= '0;
      out_dat  <= '0;
    end else begin
      rd_issue <= 1'b0;
      out_en   <= '0;
      if (state == IDLE && trg) begin
        num_q    <= num_words;
        rev_q    <= rev_order;
        rd_adr   <= start_adr;
        k_cnt    <= '0;
        s_cnt    <= '0;
        last_q   <= 1'b0;
        rd_issue <= (num_words != '0);
      end
      if (emit) begin
        out_en  <= '1;
        out_dat <= sel_dat;
        if (last_sample) begin
          s_cnt <= '0;
          if (last_word) last_q <= 1'b1;
          else           k_cnt  <= k_cnt + K_ONE;
        end else begin
          s_cnt <= s_cnt + SW'(1);
        end
        // Issue the next word two samples early so its read data lands exactly at s wrap.
        if (s_cnt == S_PREF && !last_word) begin
          rd_adr   <= rd_adr + AW'(1);
          rd_issue <= 1'b1;
        end
      end
      if (state == DONE) last_q <= 1'b0;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [PW-1:0]       mem [0:2**AW-1];
    logic [PW-1:0]       wpack;
    logic [PW-1:0]       ram_q;
    logic [SAMPLE_W-1:0] lane_pick;

    always_comb begin
      wpack = '0;
      for (int i = 0; i < PACK_N; i++)
        wpack[i*SAMPLE_W +: SAMPLE_W] = wdat[c*BUS_W + i*LANE_W +: SAMPLE_W];
    end

    // Read only on issue cycles so a same-cycle write cannot leak into the word in flight.
    always_ff @(posedge clk_250MHz) begin
      if (wen[c])   mem[wadrs[c*AW +: AW]] <= wpack;
      if (rd_issue) ram_q <= mem[rd_adr];
    end

    always_comb begin
      lane_pick = '0;
      for (int i = 0; i < PACK_N; i++)
        if (lane_sel == SW'(i)) lane_pick = ram_q[i*SAMPLE_W +: SAMPLE_W];
    end

    assign sel_dat[c*SAMPLE_W +: SAMPLE_W] = lane_pick;
  end

endmodule
